// File: rtl/paquete_alu_pkg.sv
// Shared types and default sizes for the 8-bit ALU block datapath.
// Used by both the input and the output block registers.
package paquete_alu_pkg;

    typedef enum logic {
        RECIBIENDO = 1'b0,
        LLENO      = 1'b1
    } estado_entrada_t;

    localparam int N_BLOQUES_DEF    = 4;
    localparam int ANCHO_BLOQUE_DEF = 8;

    // Index width that stays legal even for degenerate block counts.
    function automatic int ancho_indice(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/contador_bloques.sv
// Modulo-N block index counter with enable and a synchronous load-to-1.
// Load wins over enable so a first block always restarts the word.
module contador_bloques
    import paquete_alu_pkg::*;
#(
    parameter int N_BLOQUES = N_BLOQUES_DEF,
    parameter int CW        = ancho_indice(N_BLOQUES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          carga_uno_i,
    output logic [CW-1:0] cuenta_o
);

    localparam logic [CW-1:0] ULTIMO = CW'(N_BLOQUES - 1);

    logic [CW-1:0] cuenta_q;
    logic [CW-1:0] cuenta_d;

    always_comb begin
        cuenta_d = cuenta_q;
        if (carga_uno_i) begin
            cuenta_d = CW'(1);
        end else if (en_i) begin
            if (cuenta_q == ULTIMO) begin
                cuenta_d = '0;
            end else begin
                cuenta_d = cuenta_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign cuenta_o = cuenta_q;

endmodule

// File: rtl/registro_entrada_bloques.sv
// Assembles a wide ALU operand from 8-bit blocks, MSB block first,
// and hands the full word to the ALU core over valid/ready.
module registro_entrada_bloques
    import paquete_alu_pkg::*;
#(
    parameter int N_BLOQUES    = N_BLOQUES_DEF,
    parameter int ANCHO_BLOQUE = ANCHO_BLOQUE_DEF,
    localparam int CW          = ancho_indice(N_BLOQUES),
    localparam int AW          = N_BLOQUES * ANCHO_BLOQUE
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ANCHO_BLOQUE-1:0] dato_in,
    input  logic                    dato_valid,
    input  logic                    dato_first,
    output logic                    dato_ready,
    output logic [AW-1:0]           palabra_out,
    output logic                    palabra_valid,
    input  logic                    palabra_ready,
    output logic [CW-1:0]           bloque_actual,
    output logic                    error_sync
);

    localparam logic [CW-1:0] ULTIMO = CW'(N_BLOQUES - 1);

    estado_entrada_t estado_q;
    logic            valid_q;
    logic            error_q;
    logic [AW-1:0]   palabra_q;
    logic [AW-1:0]   palabra_d;
    logic [CW-1:0]   cuenta;
    logic [CW-1:0]   indice;
    logic            transfer;
    logic            ultimo;
    logic            resync;

    assign dato_ready = (estado_q == RECIBIENDO);
    assign transfer   = dato_valid & dato_ready;
    assign indice     = dato_first ? '0 : cuenta;
    assign ultimo     = transfer & ~dato_first & (cuenta == ULTIMO);
    assign resync     = transfer & dato_first & (cuenta != '0);

    contador_bloques #(
        .N_BLOQUES (N_BLOQUES),
        .CW        (CW)
    ) u_contador (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (transfer),
        .carga_uno_i (transfer & dato_first),
        .cuenta_o    (cuenta)
    );

    // Only the addressed block slot changes; the rest of the word holds.
    always_comb begin
        palabra_d = palabra_q;
        if (transfer) begin
            for (int k = 0; k < N_BLOQUES; k++) begin
                if (indice == CW'(k)) begin
                    palabra_d[ANCHO_BLOQUE*(N_BLOQUES-k)-1 -: ANCHO_BLOQUE] = dato_in;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            palabra_q <= '0;
        end else begin
            palabra_q <= palabra_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= RECIBIENDO;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            error_q <= resync;
            unique case (estado_q)
                RECIBIENDO: begin
                    if (ultimo) begin
                        estado_q <= LLENO;
                        valid_q  <= 1'b1;
                    end
                end
                LLENO: begin
                    if (palabra_ready) begin
                        estado_q <= RECIBIENDO;
                        valid_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign palabra_out   = palabra_q;
    assign palabra_valid = valid_q;
    assign bloque_actual = cuenta;
    assign error_sync    = error_q;

endmodule

// File: tb/tb_registro_entrada_bloques.sv
// Directed bench for registro_entrada_bloques with a word scoreboard.
// Expected words are queued as blocks are sent and checked on handshake.
module tb_registro_entrada_bloques;

    logic        clk;
    logic        rst_n;
    logic [7:0]  dato_in;
    logic        dato_valid;
    logic        dato_first;
    logic        dato_ready;
    logic [31:0] palabra_out;
    logic        palabra_valid;
    logic        palabra_ready;
    logic [1:0]  bloque_actual;
    logic        error_sync;

    int          total;
    int          bad;
    int          popped;
    int          waits;
    logic [31:0] sb[$];

    registro_entrada_bloques dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dato_in       (dato_in),
        .dato_valid    (dato_valid),
        .dato_first    (dato_first),
        .dato_ready    (dato_ready),
        .palabra_out   (palabra_out),
        .palabra_valid (palabra_valid),
        .palabra_ready (palabra_ready),
        .bloque_actual (bloque_actual),
        .error_sync    (error_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic blk(input logic [7:0] b, input logic f);
        dato_in    = b;
        dato_valid = 1'b1;
        dato_first = f;
        tick();
    endtask

    task automatic idle();
        dato_valid = 1'b0;
        dato_first = 1'b0;
        tick();
    endtask

    // Holds the block until the DUT is ready, counting stall cycles.
    task automatic blk_hs(input logic [7:0] b, input logic f,
                          inout int w);
        dato_in    = b;
        dato_valid = 1'b1;
        dato_first = f;
        for (int n = 0; n < 4 && !dato_ready; n++) begin
            tick();
            w++;
        end
        if (!dato_ready) begin
            total++;
            bad++;
            $error("FAIL hs_timeout observed=%b expected=1", dato_ready);
        end
        tick();
    endtask

    task automatic consume();
        dato_valid    = 1'b0;
        dato_first    = 1'b0;
        palabra_ready = 1'b1;
        tick();
        palabra_ready = 1'b0;
        chk("consume_valid", palabra_valid, 0);
        chk("consume_ready", dato_ready, 1);
    endtask

    always @(negedge clk) begin
        if (rst_n && palabra_valid && palabra_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL sb_empty observed=%h expected=none", palabra_out);
            end else begin
                popped++;
                chk("sb_word", palabra_out, sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        total         = 0;
        bad           = 0;
        popped        = 0;
        waits         = 0;
        rst_n         = 1'b0;
        dato_in       = '0;
        dato_valid    = 1'b0;
        dato_first    = 1'b0;
        palabra_ready = 1'b0;
        tick();
        tick();
        chk("rst_ready", dato_ready, 1);
        chk("rst_valid", palabra_valid, 0);
        chk("rst_word", palabra_out, 32'h0);
        chk("rst_idx", bloque_actual, 0);
        chk("rst_err", error_sync, 0);
        rst_n = 1'b1;
        tick();

        blk(8'hDE, 1'b1);
        chk("w1_b0", palabra_out, 32'hDE00_0000);
        chk("w1_idx1", bloque_actual, 1);
        blk(8'hAD, 1'b0);
        blk(8'hBE, 1'b0);
        blk(8'hEF, 1'b0);
        sb.push_back(32'hDEAD_BEEF);
        chk("w1_valid", palabra_valid, 1);
        chk("w1_word", palabra_out, 32'hDEAD_BEEF);
        chk("w1_ready", dato_ready, 0);
        chk("w1_idx0", bloque_actual, 0);

        dato_in    = 8'h11;
        dato_valid = 1'b1;
        dato_first = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_word", palabra_out, 32'hDEAD_BEEF);
            chk("bp_idx", bloque_actual, 0);
        end
        palabra_ready = 1'b1;
        tick();
        palabra_ready = 1'b0;
        chk("bp_valid", palabra_valid, 0);
        chk("bp_ready", dato_ready, 1);
        chk("bp_nobypass", palabra_out, 32'hDEAD_BEEF);
        tick();
        chk("bp_acc", palabra_out, 32'h11AD_BEEF);
        chk("bp_idx1", bloque_actual, 1);
        blk(8'h22, 1'b0);
        blk(8'h33, 1'b0);
        blk(8'h44, 1'b0);
        sb.push_back(32'h1122_3344);
        chk("bp_word2", palabra_out, 32'h1122_3344);
        consume();

        blk(8'h01, 1'b1);
        blk(8'h02, 1'b0);
        chk("rs_idx2", bloque_actual, 2);
        chk("rs_err0", error_sync, 0);
        blk(8'hA0, 1'b1);
        chk("rs_err1", error_sync, 1);
        chk("rs_idx1", bloque_actual, 1);
        blk(8'hA1, 1'b0);
        chk("rs_errclr", error_sync, 0);
        blk(8'hA2, 1'b0);
        blk(8'hA3, 1'b0);
        sb.push_back(32'hA0A1_A2A3);
        chk("rs_word", palabra_out, 32'hA0A1_A2A3);
        chk("rs_valid", palabra_valid, 1);
        consume();

        blk(8'h12, 1'b1);
        chk("gp_idx_a", bloque_actual, 1);
        chk("gp_err", error_sync, 0);
        idle();
        chk("gp_idx_b", bloque_actual, 1);
        blk(8'h34, 1'b0);
        chk("gp_idx_c", bloque_actual, 2);
        idle();
        blk(8'h56, 1'b0);
        chk("gp_idx_d", bloque_actual, 3);
        idle();
        chk("gp_novalid", palabra_valid, 0);
        blk(8'h78, 1'b0);
        sb.push_back(32'h1234_5678);
        chk("gp_idx_e", bloque_actual, 0);
        idle();
        chk("gp_word", palabra_out, 32'h1234_5678);
        chk("gp_valid", palabra_valid, 1);
        consume();

        blk(8'h55, 1'b1);
        blk(8'h66, 1'b0);
        dato_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_idx", bloque_actual, 0);
        chk("mr_word", palabra_out, 32'h0);
        chk("mr_ready", dato_ready, 1);
        #2;
        rst_n = 1'b1;
        tick();
        blk(8'h9A, 1'b0);
        chk("mr_b0", palabra_out, 32'h9A00_0000);
        blk(8'hBC, 1'b0);
        blk(8'hDE, 1'b0);
        blk(8'hF0, 1'b0);
        sb.push_back(32'h9ABC_DEF0);
        chk("mr_word2", palabra_out, 32'h9ABC_DEF0);
        consume();

        palabra_ready = 1'b1;
        waits = 0;
        for (int i = 0; i < 8; i++) begin
            blk_hs(8'(i + 1), (i % 4) == 0, waits);
            if ((i % 4) == 3) begin
                sb.push_back(i == 3 ? 32'h0102_0304 : 32'h0506_0708);
                chk("bb_valid", palabra_valid, 1);
            end
        end
        dato_valid = 1'b0;
        tick();
        palabra_ready = 1'b0;
        chk("bb_gap", waits, 1);
        chk("bb_drop", palabra_valid, 0);
        chk("bb_words", popped, 7);
        chk("bb_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
